seq_serializer: RTL

SEQ_SERIALIZER -- requirements
Module: seq_serializer

---
 rtl/seq_serializer.sv | 117 +++++++++++
 1 files changed

// File: rtl/seq_serializer.sv
// seq_serializer: accepts a parallel word over a Valid/Ready handshake and emits it one bit per Clk.
// Defining SER_PARITY_EN appends one even-parity bit to every frame.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Data,
  input  logic             Valid,
  output logic             Ready,
  output logic             Out,
  output logic             Out_valid,
  output logic             Busy
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, PARITY = 2'b10} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01} state_t;
`endif

  state_t           state, state_d;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             par;
`endif

  assign last   = (cnt == LAST);
  assign accept = Valid & Ready;

  // NOTE: every output of this block is given a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = IDLE;
    Ready   = 1'b0;
    Busy    = 1'b0;
    case (state)
      IDLE: begin
        Ready   = 1'b1;
        state_d = Valid ? SHIFT : IDLE;
      end
      SHIFT: begin
        Busy = 1'b1;
        if (!last) begin
          state_d = SHIFT;
        end else begin
`ifdef SER_PARITY_EN
          state_d = PARITY;
`else
          Ready   = 1'b1;
          state_d = Valid ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        Busy    = 1'b1;
        Ready   = 1'b1;
        state_d = Valid ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_d;
  end

  // The first bit is driven straight from Data at the accepting edge; later bits come from the shift register.
  // NOTE: the shift register is a plain register, not a memory, so it is cleared by reset like the rest.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sreg      <= '0;
      cnt       <= '0;
      Out       <= 1'b0;
      Out_valid <= 1'b0;
`ifdef SER_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (accept) begin
      sreg      <= Data;
      cnt       <= '0;
      Out       <= MSB_FIRST ? Data[WIDTH-1] : Data[0];
      Out_valid <= 1'b1;
`ifdef SER_PARITY_EN
      par       <= ^Data;
`endif
    end else if (state == SHIFT && !last) begin
      sreg      <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
      Out       <= MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
      Out_valid <= 1'b1;
      cnt       <= cnt + 1'b1;
    end
`ifdef SER_PARITY_EN
    else if (state == SHIFT) begin
      cnt       <= '0;
      Out       <= par;
      Out_valid <= 1'b1;
    end
`endif
    else begin
      cnt       <= '0;
      Out       <= 1'b0;
      Out_valid <= 1'b0;
    end
  end

endmodule
